enemy_hit_detector: RTL

Per-enemy damage tracker that sits directly upstream of the enemy movement/collision block. It watches pixel-level overlap between the enemy's drawing request and the three player-bullet drawing requests, accumulates hits over a full video frame, and applies damage once per frame. It then runs a health/invulnerability state machine. It drives the movement block's 3-bit `shotCollision` input, which is non-zero only on the kill frame, and returns per-bullet hit pulses so the bullet blocks can despawn.

---
 rtl/enemy_hit_detector.sv | 126 ++++++++++++
 1 files changed

// File: rtl/enemy_hit_detector.sv
// -----------------------------------------------------------------------------
// enemy_hit_detector
//
// Per-enemy damage tracker. Collects pixel overlaps between the enemy and the
// three player bullets over one video frame. At each frame boundary it applies
// at most one damage, then steps a health/invulnerability state machine.
//
// Ports:
//   clk            pixel clock (only clock)
//   reset          synchronous active-high reset
//   startOfFrame   one-cycle frame-boundary strobe
//   enemyDR        enemy drawing request, current pixel
//   bulletDR[2:0]  drawing requests of player bullets 0..2, current pixel
//   pause          freezes damage evaluation and the flash counter
//   shotCollision  one-cycle pulse on the kill frame, bit i = bullet i hit
//   bulletHit      one-cycle pulse per evaluated frame, bit i = bullet i despawns
//   hitFlash       high while invulnerable after a non-lethal hit
//   killed         high once the enemy is dead
//   hitCount       damaged frames taken so far (saturates at HITS_TO_KILL)
// -----------------------------------------------------------------------------
module enemy_hit_detector #(
  parameter int HITS_TO_KILL = 3,
  parameter int FLASH_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enemyDR,
  input  logic [2:0] bulletDR,
  input  logic       pause,
  output logic [2:0] shotCollision,
  output logic [2:0] bulletHit,
  output logic       hitFlash,
  output logic       killed,
  output logic [3:0] hitCount
);

  localparam logic [3:0] KILL_CNT  = 4'(HITS_TO_KILL);
  localparam logic [5:0] FLASH_LEN = 6'(FLASH_FRAMES);

  typedef enum logic [1:0] {ALIVE, FLASH, DEAD} state_t;

  // Damage counter never wraps past the kill threshold.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= KILL_CNT) ? KILL_CNT : cnt + 4'd1;
  endfunction

  // Stage 0: pixel overlap and next-state computation
  logic [2:0] ov_p0;
  logic [2:0] acc_p0;
  state_t     state_p0;
  logic [5:0] flash_cnt_p0;
  logic [3:0] hit_count_p0;
  logic [2:0] bullet_hit_p0;
  logic [2:0] shot_p0;

  // Stage 1: registered state and outputs
  logic [2:0] acc_p1;
  state_t     state_p1;
  logic [5:0] flash_cnt_p1;
  logic [3:0] hit_count_p1;
  logic [2:0] bullet_hit_p1;
  logic [2:0] shot_p1;

  assign ov_p0 = bulletDR & {3{enemyDR}};

  always_comb begin
    state_p0      = state_p1;
    flash_cnt_p0  = flash_cnt_p1;
    hit_count_p0  = hit_count_p1;
    bullet_hit_p0 = 3'b000;
    shot_p0       = 3'b000;
    // The boundary pixel already belongs to the new frame.
    acc_p0        = startOfFrame ? ov_p0 : (acc_p1 | ov_p0);

    if (startOfFrame && !pause) begin
      unique case (state_p1)
        ALIVE: begin
          if (acc_p1 != 3'b000) begin
            bullet_hit_p0 = acc_p1;
            hit_count_p0  = sat_inc(hit_count_p1);
            if (hit_count_p0 == KILL_CNT) begin
              state_p0 = DEAD;
              shot_p0  = acc_p1;
            end else begin
              state_p0     = FLASH;
              flash_cnt_p0 = FLASH_LEN;
            end
          end
        end
        FLASH: begin
          // Bullets still despawn while invulnerable, but deal no damage.
          bullet_hit_p0 = acc_p1;
          flash_cnt_p0  = flash_cnt_p1 - 6'd1;
          if (flash_cnt_p1 == 6'd1) state_p0 = ALIVE;
        end
        default: ;  // DEAD absorbs until reset
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1        <= 3'b000;
      state_p1      <= ALIVE;
      flash_cnt_p1  <= 6'd0;
      hit_count_p1  <= 4'd0;
      bullet_hit_p1 <= 3'b000;
      shot_p1       <= 3'b000;
    end else begin
      acc_p1        <= acc_p0;
      state_p1      <= state_p0;
      flash_cnt_p1  <= flash_cnt_p0;
      hit_count_p1  <= hit_count_p0;
      bullet_hit_p1 <= bullet_hit_p0;
      shot_p1       <= shot_p0;
    end
  end

  assign shotCollision = shot_p1;
  assign bulletHit     = bullet_hit_p1;
  assign hitFlash      = (state_p1 == FLASH);
  assign killed        = (state_p1 == DEAD);
  assign hitCount      = hit_count_p1;

endmodule
